// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : rst_seq_pkg                                                   |
// | Purpose    : Shared types and constants for the reset sequencer:           |
// |              sequencer state encoding, lock-loss counter width and a       |
// |              counter-width helper.                                         |
// | Ports      : n/a (package)                                                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package rst_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_t;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_sync_ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sync_ff                                                       |
// | Purpose    : N-stage single-bit synchroniser, asynchronous active-low      |
// |              reset clearing every stage to 0.                              |
// | Ports      : clk   in  sampling clock                                      |
// |              rst_n in  async active-low reset                              |
// |              d_i   in  asynchronous input bit                              |
// |              q_o   out synchronised bit (last stage)                       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rst_seq                                                       |
// | Purpose    : Reset sequencer. Synchronises and filters PLL lock, then      |
// |              releases NUM_DOMAINS active-low resets one by one, spaced     |
// |              STAGE_GAP edges apart. Lock loss or a software request        |
// |              returns everything to reset.                                  |
// | Ports      : clk           in  sole clock                                  |
// |              rst_n         in  async active-low reset                      |
// |              locked        in  PLL lock (asynchronous)                     |
// |              sw_rst_req    in  synchronous software reset level           |
// |              rst_n_out     out per-domain active-low resets (registered)   |
// |              ready         out all domains released                        |
// |              lock_loss_cnt out saturating lock-loss event count            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   locked,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

  localparam int FW = cnt_w(LOCK_FILTER);
  localparam int GW = cnt_w(STAGE_GAP);
  localparam int DW = cnt_w(NUM_DOMAINS);

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

  logic lock_s;
  logic abort;

  rst_seq_state_t           state_q,     state_d;
  logic [FW-1:0]            fcnt_q,      fcnt_d;
  logic [GW-1:0]            gcnt_q,      gcnt_d;
  logic [DW-1:0]            dom_q,       dom_d;
  logic [NUM_DOMAINS-1:0]   rst_n_out_q, rst_n_out_d;
  logic                     ready_q,     ready_d;
  logic [LOSS_CNT_W-1:0]    loss_q,      loss_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  assign abort = sw_rst_req | ~lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      gcnt_q      <= '0;
      dom_q       <= '0;
      rst_n_out_q <= '0;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      gcnt_q      <= gcnt_d;
      dom_q       <= dom_d;
      rst_n_out_q <= rst_n_out_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    gcnt_d      = gcnt_q;
    dom_d       = dom_q;
    rst_n_out_d = rst_n_out_q;
    ready_d     = ready_q;
    loss_d      = loss_q;

    if (abort) begin
      // Abort wins over every other transition.
      state_d     = IDLE;
      fcnt_d      = '0;
      gcnt_d      = '0;
      dom_d       = '0;
      rst_n_out_d = '0;
      ready_d     = 1'b0;
      // Only a lost lock that knocks us out of an active state is an event;
      // a coincident software request still counts as a lock loss.
      if (!lock_s && (state_q != IDLE) && (loss_q != '1)) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILTER;
          fcnt_d  = '0;
        end

        FILTER: begin
          if (fcnt_q == FILT_LAST) begin
            rst_n_out_d[0] = 1'b1;
            fcnt_d         = '0;
            gcnt_d         = '0;
            dom_d          = '0;
            if (NUM_DOMAINS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end

        RELEASE: begin
          if (gcnt_q == GAP_LAST) begin
            gcnt_d = '0;
            dom_d  = dom_q + DW'(1);
            for (int i = 1; i < NUM_DOMAINS; i++) begin
              if (i == int'(dom_q) + 1) begin
                rst_n_out_d[i] = 1'b1;
              end
            end
            // dom_q is the most recently released domain; releasing the
            // last one ends the sequence.
            if (int'(dom_q) + 2 == NUM_DOMAINS) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end

        RUN: begin
          state_d = RUN;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign rst_n_out     = rst_n_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_rst_seq                                                    |
// | Purpose    : Self-checking bench for rst_seq. Expected output snapshots    |
// |              are queued with the edge at which they must hold and are      |
// |              compared on the falling clock edge after that rising edge.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sw_rst_req;

  logic [2:0] rn0;
  logic       rdy0;
  logic [7:0] llc0;
  logic [0:0] rn1;
  logic       rdy1;
  logic [7:0] llc1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_DOMAINS (3),
    .SYNC_STAGES (2),
    .LOCK_FILTER (16),
    .STAGE_GAP   (8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .sw_rst_req    (sw_rst_req),
    .rst_n_out     (rn0),
    .ready         (rdy0),
    .lock_loss_cnt (llc0)
  );

  rst_seq #(
    .NUM_DOMAINS (1),
    .SYNC_STAGES (2),
    .LOCK_FILTER (1),
    .STAGE_GAP   (1)
  ) u_dut_min (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .sw_rst_req    (sw_rst_req),
    .rst_n_out     (rn1),
    .ready         (rdy1),
    .lock_loss_cnt (llc1)
  );

  // Edge 1 is the first rising edge after rst_n deasserts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    int         sel;
    int         at;
    logic [2:0] rn;
    logic       rdy;
    logic [7:0] llc;
  } exp_t;

  exp_t sbq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input int at,
                          input logic [2:0] rn, input logic rdy, input logic [7:0] llc);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.at  = at;
    e.rn  = rn;
    e.rdy = rdy;
    e.llc = llc;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      if (e.at != cyc) check_eq({e.tag, "_late"}, 32'(cyc), 32'(e.at));
      if (e.sel == 0) begin
        check_eq({e.tag, "_rn"},  32'(rn0),  32'(e.rn));
        check_eq({e.tag, "_rdy"}, 32'(rdy0), 32'(e.rdy));
        check_eq({e.tag, "_llc"}, 32'(llc0), 32'(e.llc));
      end else begin
        check_eq({e.tag, "_rn"},  32'(rn1),  32'(e.rn[0]));
        check_eq({e.tag, "_rdy"}, 32'(rdy1), 32'(e.rdy));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n      = 1'b0;
    locked     = 1'b1;
    sw_rst_req = 1'b0;

    #3;
    check_eq("rst_rn",   32'(rn0),  32'd0);
    check_eq("rst_rdy",  32'(rdy0), 32'd0);
    check_eq("rst_llc",  32'(llc0), 32'd0);
    check_eq("rst_rn1",  32'(rn1),  32'd0);
    check_eq("rst_rdy1", 32'(rdy1), 32'd0);

    // Power-up with lock already present.
    push_exp("min_pre", 1,  3, 3'b000, 1'b0, 8'd0);
    push_exp("min_rel", 1,  4, 3'b001, 1'b1, 8'd0);
    push_exp("pu_d0_pre", 0, 18, 3'b000, 1'b0, 8'd0);
    push_exp("pu_d0",     0, 19, 3'b001, 1'b0, 8'd0);
    push_exp("pu_d1_pre", 0, 26, 3'b001, 1'b0, 8'd0);
    push_exp("pu_d1",     0, 27, 3'b011, 1'b0, 8'd0);
    push_exp("pu_d2_pre", 0, 34, 3'b011, 1'b0, 8'd0);
    push_exp("pu_d2",     0, 35, 3'b111, 1'b1, 8'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock loss in RUN: locked falls before edge 41, outputs drop at 43.
    wait_cyc(40);
    locked = 1'b0;
    push_exp("run_loss_pre", 0, 42, 3'b111, 1'b1, 8'd0);
    push_exp("run_loss",     0, 43, 3'b000, 1'b0, 8'd1);

    // Relock before edge 46 -> FILTER at 48.
    wait_cyc(45);
    locked = 1'b1;

    // Glitch mid-FILTER: low before edge 55 -> abort at 57.
    wait_cyc(54);
    locked = 1'b0;
    push_exp("flt_loss_pre", 0, 56, 3'b000, 1'b0, 8'd1);
    push_exp("flt_loss",     0, 57, 3'b000, 1'b0, 8'd2);

    // Relock before edge 60 -> FILTER at 62 -> domain 0 at 78.
    wait_cyc(59);
    locked = 1'b1;
    push_exp("rl_d0_pre", 0, 77, 3'b000, 1'b0, 8'd2);
    push_exp("rl_d0",     0, 78, 3'b001, 1'b0, 8'd2);
    push_exp("rl_d1_pre", 0, 85, 3'b001, 1'b0, 8'd2);
    push_exp("rl_d1",     0, 86, 3'b011, 1'b0, 8'd2);
    push_exp("rl_d2_pre", 0, 93, 3'b011, 1'b0, 8'd2);
    push_exp("rl_d2",     0, 94, 3'b111, 1'b1, 8'd2);

    // One-cycle software reset sampled at edge 100.
    wait_cyc(95);
    push_exp("sw_pre",    0,  99, 3'b111, 1'b1, 8'd2);
    push_exp("sw_abort",  0, 100, 3'b000, 1'b0, 8'd2);
    push_exp("sw_d0_pre", 0, 116, 3'b000, 1'b0, 8'd2);
    push_exp("sw_d0",     0, 117, 3'b001, 1'b0, 8'd2);
    push_exp("sw_run",    0, 133, 3'b111, 1'b1, 8'd2);
    wait_cyc(99);
    sw_rst_req = 1'b1;
    wait_cyc(100);
    sw_rst_req = 1'b0;

    // 300 lock-loss events, one every 6 edges.
    for (int k = 1; k <= 300; k++) begin
      c = 140 + (k - 1) * 6;
      wait_cyc(c);
      locked = 1'b0;
      wait_cyc(c + 3);
      if (k == 1 || k == 252 || k == 253 || k == 300) begin
        push_exp("loss_sat", 0, c + 4, 3'b000, 1'b0, 8'(((2 + k) > 255) ? 255 : (2 + k)));
      end
      locked = 1'b1;
    end

    // Last relock before edge 1938 -> FILTER 1940 -> domain 0 at 1956.
    wait_cyc(1940);
    push_exp("fin_d0_pre", 0, 1955, 3'b000, 1'b0, 8'd255);
    push_exp("fin_d0",     0, 1956, 3'b001, 1'b0, 8'd255);
    push_exp("fin_run",    0, 1972, 3'b111, 1'b1, 8'd255);

    wait_cyc(1982);
    check_eq("sb_drain", 32'(sbq.size()), 32'd0);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rn",   32'(rn0),  32'd0);
    check_eq("arst_rdy",  32'(rdy0), 32'd0);
    check_eq("arst_llc",  32'(llc0), 32'd0);
    check_eq("arst_rn1",  32'(rn1),  32'd0);
    check_eq("arst_rdy1", 32'(rdy1), 32'd0);
    #30;
    check_eq("hold_rn",  32'(rn0),  32'd0);
    check_eq("hold_rdy", 32'(rdy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
